// File: rtl/nts_timestamp_mc_if.sv
// nts_timestamp_mc bus bundle: 32-bit API bus plus shared TX header path.
// The DUT takes the slave modport; the host/TX side takes master.
interface nts_timestamp_mc_if #(
  parameter int CH_W = 2
);
  logic            i_api_cs;
  logic            i_api_we;
  logic [7:0]      i_api_address;
  logic [31:0]     i_api_write_data;
  logic [31:0]     o_api_read_data;
  logic            o_tx_wr_en;
  logic [CH_W-1:0] o_tx_channel;
  logic [2:0]      o_tx_ntp_header_block;
  logic [63:0]     o_tx_ntp_header_data;

  modport slave (
    input  i_api_cs,
    input  i_api_we,
    input  i_api_address,
    input  i_api_write_data,
    output o_api_read_data,
    output o_tx_wr_en,
    output o_tx_channel,
    output o_tx_ntp_header_block,
    output o_tx_ntp_header_data
  );

  modport master (
    output i_api_cs,
    output i_api_we,
    output i_api_address,
    output i_api_write_data,
    input  o_api_read_data,
    input  o_tx_wr_en,
    input  o_tx_channel,
    input  o_tx_ntp_header_block,
    input  o_tx_ntp_header_data
  );
endinterface

// File: rtl/nts_timestamp_mc.sv
// nts_timestamp_mc: multi-channel NTP server header emitter, round-robin.
// Optional per-channel burst counters under NTS_TIMESTAMP_MC_STATS_EN.
module nts_timestamp_mc #(
  parameter int CHANNELS          = 4,
  parameter int CH_W              = 2,
  parameter bit TX_OFS_EN_DEFAULT = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_areset,
  input  logic [63:0]             i_ntp_time,
  input  logic [CHANNELS-1:0]     i_parser_clear,
  input  logic [CHANNELS-1:0]     i_parser_record_receive_timestamp,
  input  logic [CHANNELS-1:0]     i_parser_transmit,
  input  logic [64*CHANNELS-1:0]  i_parser_origin_timestamp,
  input  logic [3*CHANNELS-1:0]   i_parser_version_number,
  input  logic [8*CHANNELS-1:0]   i_parser_poll,
  output logic [CHANNELS-1:0]     o_parser_busy,
  nts_timestamp_mc_if.slave       tx_api
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state_q, state_d;

  logic [63:0] rx_q   [CHANNELS];
  logic [63:0] rx_d   [CHANNELS];
  logic [63:0] org_q  [CHANNELS];
  logic [63:0] org_d  [CHANNELS];
  logic [2:0]  vn_q   [CHANNELS];
  logic [2:0]  vn_d   [CHANNELS];
  logic [7:0]  poll_q [CHANNELS];
  logic [7:0]  poll_d [CHANNELS];

  logic [CHANNELS-1:0] pend_q, pend_d;

  logic [31:0] cfg_q, cfg_d;
  logic [31:0] rdly_q, rdly_d;
  logic [31:0] rdsp_q, rdsp_d;
  logic [31:0] refid_q, refid_d;
  logic [31:0] ofs_q, ofs_d;
  logic [31:0] rdata_q, rdata_d;

  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [2:0]      blk_q, blk_d;
  logic [63:0]     ts_q, ts_d;
  logic [63:0]     rxg_q, rxg_d;

  logic            wr_q, wr_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [2:0]      ob_q, ob_d;
  logic [63:0]     dat_q, dat_d;

`ifdef NTS_TIMESTAMP_MC_STATS_EN
  logic [31:0] cnt_q [CHANNELS];
  logic [31:0] cnt_d [CHANNELS];
`endif

  logic            found;
  logic [CH_W-1:0] sel;
  logic [CH_W:0]   idx;
  logic [2:0]      vn_g;

  function automatic logic [2:0] vn_fix(input logic [2:0] v);
    return (v == 3'd3 || v == 3'd4) ? v : 3'd4;
  endfunction

  // Round-robin pick: first pending channel at or after the pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(CHANNELS))
        idx = idx - (CH_W+1)'(CHANNELS);
      if (!found && pend_q[idx[CH_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[CH_W-1:0];
      end
    end
  end

  // A channel stays busy until its own burst has fully left.
  always_comb begin
    o_parser_busy = pend_q;
    if (state_q == EMIT)
      o_parser_busy[grant_q] = 1'b1;
  end

  // API, per-channel request state and emit FSM next-state logic.
  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    org_d   = org_q;
    vn_d    = vn_q;
    poll_d  = poll_q;
    pend_d  = pend_q;
    cfg_d   = cfg_q;
    rdly_d  = rdly_q;
    rdsp_d  = rdsp_q;
    refid_d = refid_q;
    ofs_d   = ofs_q;
    rdata_d = '0;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    blk_d   = blk_q;
    ts_d    = ts_q;
    rxg_d   = rxg_q;
    wr_d    = 1'b0;
    ch_d    = '0;
    ob_d    = '0;
    dat_d   = '0;
    vn_g    = vn_fix(vn_q[grant_q]);
`ifdef NTS_TIMESTAMP_MC_STATS_EN
    cnt_d   = cnt_q;
`endif

    if (tx_api.i_api_cs && !tx_api.i_api_we) begin
      case (tx_api.i_api_address)
        8'h00:   rdata_d = 32'h7469_6d65;
        8'h01:   rdata_d = 32'h7374_6d70;
        8'h02:   rdata_d = 32'h0002_0000;
        8'h03:   rdata_d = 32'(CHANNELS);
        8'h10:   rdata_d = cfg_q;
        8'h11:   rdata_d = rdly_q;
        8'h12:   rdata_d = rdsp_q;
        8'h13:   rdata_d = refid_q;
        8'h14:   rdata_d = ofs_q;
        default: rdata_d = '0;
      endcase
`ifdef NTS_TIMESTAMP_MC_STATS_EN
      for (int c = 0; c < CHANNELS; c++)
        if (tx_api.i_api_address == 8'h20 + 8'(c))
          rdata_d = cnt_q[c];
`endif
    end

    if (tx_api.i_api_cs && tx_api.i_api_we) begin
      case (tx_api.i_api_address)
        8'h10:   cfg_d   = tx_api.i_api_write_data;
        8'h11:   rdly_d  = tx_api.i_api_write_data;
        8'h12:   rdsp_d  = tx_api.i_api_write_data;
        8'h13:   refid_d = tx_api.i_api_write_data;
        8'h14:   ofs_d   = tx_api.i_api_write_data;
        default: ;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = EMIT;
          grant_d = sel;
          blk_d   = '0;
          rxg_d   = rx_q[sel];
          ts_d    = i_ntp_time +
                    (cfg_q[0] ? {32'h0, ofs_q} : 64'h0);
        end
      end
      EMIT: begin
        wr_d = 1'b1;
        ch_d = grant_q;
        ob_d = blk_q;
        unique case (blk_q)
          3'd0: dat_d = {cfg_q[31:30], vn_g, 3'd4,
                         cfg_q[23:16], poll_q[grant_q],
                         cfg_q[15:8], rdly_q};
          3'd1: dat_d = {rdsp_q, refid_q};
          3'd2: dat_d = {ts_q[63:32] - 32'd1, 32'h0};
          3'd3: dat_d = org_q[grant_q];
          3'd4: dat_d = rxg_q;
          3'd5: dat_d = ts_q;
          default: dat_d = '0;
        endcase
        if (blk_q == 3'd5) begin
          state_d         = IDLE;
          pend_d[grant_q] = 1'b0;
          ptr_d = (grant_q == CH_W'(CHANNELS-1)) ?
                  '0 : grant_q + 1'b1;
`ifdef NTS_TIMESTAMP_MC_STATS_EN
          if (cnt_q[grant_q] != 32'hffff_ffff)
            cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
`endif
        end else begin
          blk_d = blk_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef NTS_TIMESTAMP_MC_STATS_EN
    if (tx_api.i_api_cs && tx_api.i_api_we &&
        tx_api.i_api_address == 8'h1f)
      for (int c = 0; c < CHANNELS; c++)
        cnt_d[c] = '0;
`endif

    for (int c = 0; c < CHANNELS; c++) begin
      if (i_parser_clear[c]) begin
        rx_d[c]   = '0;
        pend_d[c] = 1'b0;
      end else begin
        if (i_parser_record_receive_timestamp[c])
          rx_d[c] = i_ntp_time;
        if (i_parser_transmit[c] && !o_parser_busy[c]) begin
          org_d[c]  = i_parser_origin_timestamp[64*c +: 64];
          vn_d[c]   = i_parser_version_number[3*c +: 3];
          poll_d[c] = i_parser_poll[8*c +: 8];
          pend_d[c] = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state_q <= IDLE;
      for (int c = 0; c < CHANNELS; c++) begin
        rx_q[c]   <= '0;
        org_q[c]  <= '0;
        vn_q[c]   <= '0;
        poll_q[c] <= '0;
`ifdef NTS_TIMESTAMP_MC_STATS_EN
        cnt_q[c]  <= '0;
`endif
      end
      pend_q  <= '0;
      cfg_q   <= {31'h0, TX_OFS_EN_DEFAULT};
      rdly_q  <= '0;
      rdsp_q  <= '0;
      refid_q <= '0;
      ofs_q   <= '0;
      rdata_q <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      blk_q   <= '0;
      ts_q    <= '0;
      rxg_q   <= '0;
      wr_q    <= 1'b0;
      ch_q    <= '0;
      ob_q    <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      org_q   <= org_d;
      vn_q    <= vn_d;
      poll_q  <= poll_d;
`ifdef NTS_TIMESTAMP_MC_STATS_EN
      cnt_q   <= cnt_d;
`endif
      pend_q  <= pend_d;
      cfg_q   <= cfg_d;
      rdly_q  <= rdly_d;
      rdsp_q  <= rdsp_d;
      refid_q <= refid_d;
      ofs_q   <= ofs_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      blk_q   <= blk_d;
      ts_q    <= ts_d;
      rxg_q   <= rxg_d;
      wr_q    <= wr_d;
      ch_q    <= ch_d;
      ob_q    <= ob_d;
      dat_q   <= dat_d;
    end
  end

  assign tx_api.o_api_read_data       = rdata_q;
  assign tx_api.o_tx_wr_en            = wr_q;
  assign tx_api.o_tx_channel          = ch_q;
  assign tx_api.o_tx_ntp_header_block = ob_q;
  assign tx_api.o_tx_ntp_header_data  = dat_q;

endmodule

// File: tb/tb_nts_timestamp_mc.sv
// tb_nts_timestamp_mc: directed scoreboard bench for nts_timestamp_mc.
// Expected header words are queued at stimulus time, popped on o_tx_wr_en.
module tb_nts_timestamp_mc;

  localparam int CH = 4;

  typedef struct {
    logic [1:0]  ch;
    logic [2:0]  blk;
    logic [63:0] d;
    bit          gap;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [63:0]   ntp;
  logic [3:0]    clr, rec, txr;
  logic [255:0]  org_bus;
  logic [11:0]   vn_bus;
  logic [31:0]   poll_bus;
  logic [3:0]    busy;

  logic [31:0] cfg, rdly, rdsp, refid, ofs;
  logic [63:0] t_org  [CH];
  logic [2:0]  t_vn   [CH];
  logic [7:0]  t_poll [CH];
  logic [63:0] t_rx   [CH];

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  nts_timestamp_mc_if #(.CH_W(2)) bus_if ();

  nts_timestamp_mc #(
    .CHANNELS(CH),
    .CH_W(2),
    .TX_OFS_EN_DEFAULT(1'b1)
  ) dut (
    .i_clk(clk),
    .i_areset(rst),
    .i_ntp_time(ntp),
    .i_parser_clear(clr),
    .i_parser_record_receive_timestamp(rec),
    .i_parser_transmit(txr),
    .i_parser_origin_timestamp(org_bus),
    .i_parser_version_number(vn_bus),
    .i_parser_poll(poll_bus),
    .o_parser_busy(busy),
    .tx_api(bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (bus_if.o_tx_wr_en === 1'b1) begin
      chk("word_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("tx_data", bus_if.o_tx_ntp_header_data, mon_e.d);
        chk("tx_channel", 64'(bus_if.o_tx_channel), 64'(mon_e.ch));
        chk("tx_block", 64'(bus_if.o_tx_ntp_header_block),
            64'(mon_e.blk));
        if (mon_e.gap)
          chk("burst_gap", 64'(cyc - last_cyc), 64'd2);
      end
      last_cyc = cyc;
    end
  end

  task automatic api_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.i_api_cs = 1'b1;
    bus_if.i_api_we = 1'b1;
    bus_if.i_api_address = a;
    bus_if.i_api_write_data = d;
    @(negedge clk);
    bus_if.i_api_cs = 1'b0;
    bus_if.i_api_we = 1'b0;
  endtask

  task automatic api_rd(input string tag, input logic [7:0] a,
                        input logic [31:0] exp);
    @(negedge clk);
    bus_if.i_api_cs = 1'b1;
    bus_if.i_api_we = 1'b0;
    bus_if.i_api_address = a;
    @(negedge clk);
    chk(tag, 64'(bus_if.o_api_read_data), 64'(exp));
    bus_if.i_api_cs = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic [63:0] o,
                        input logic [2:0] v, input logic [7:0] p);
    t_org[c] = o;
    t_vn[c] = v;
    t_poll[c] = p;
    org_bus[64*c +: 64] = o;
    vn_bus[3*c +: 3] = v;
    poll_bus[8*c +: 8] = p;
  endtask

  task automatic cap(input logic [3:0] m, input logic [63:0] tm);
    @(negedge clk);
    ntp = tm;
    rec = m;
    @(negedge clk);
    rec = '0;
    for (int c = 0; c < CH; c++)
      if (m[c]) t_rx[c] = tm;
  endtask

  task automatic push_hdr(input int c, input logic [63:0] tg,
                          input bit gap);
    logic [63:0] ts;
    logic [2:0]  vp;
    logic [63:0] w [6];
    exp_t e;
    ts = tg + (cfg[0] ? {32'h0, ofs} : 64'h0);
    vp = (t_vn[c] == 3'd3 || t_vn[c] == 3'd4) ? t_vn[c] : 3'd4;
    w[0] = {cfg[31:30], vp, 3'd4, cfg[23:16], t_poll[c],
            cfg[15:8], rdly};
    w[1] = {rdsp, refid};
    w[2] = {ts[63:32] - 32'd1, 32'h0};
    w[3] = t_org[c];
    w[4] = t_rx[c];
    w[5] = ts;
    for (int b = 0; b < 6; b++) begin
      e.ch = 2'(c);
      e.blk = 3'(b);
      e.d = w[b];
      e.gap = gap && (b == 0);
      q.push_back(e);
    end
  endtask

  task automatic pulse_tx(input logic [3:0] m);
    @(negedge clk);
    txr = m;
    @(negedge clk);
    txr = '0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [63:0] t1, t2, t3, t4, t5;
    bit seen;
    t1 = 64'h1234_5678_9abc_def0;
    t2 = 64'h1234_5679_0000_1000;
    t3 = 64'h0000_0010_ffff_ff80;
    t4 = 64'hcafe_0001_0000_0042;
    t5 = 64'hcafe_0002_8000_0000;
    rst = 1'b1;
    ntp = '0;
    clr = '0;
    rec = '0;
    txr = '0;
    org_bus = '0;
    vn_bus = '0;
    poll_bus = '0;
    bus_if.i_api_cs = 1'b0;
    bus_if.i_api_we = 1'b0;
    bus_if.i_api_address = '0;
    bus_if.i_api_write_data = '0;
    cfg = 32'h1;
    rdly = '0;
    rdsp = '0;
    refid = '0;
    ofs = '0;
    for (int c = 0; c < CH; c++) begin
      t_org[c] = '0;
      t_vn[c] = '0;
      t_poll[c] = '0;
      t_rx[c] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", 64'(bus_if.o_tx_wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", bus_if.o_tx_ntp_header_data, 64'd0);
    chk("rst_rdata", 64'(bus_if.o_api_read_data), 64'd0);

    api_rd("rd_name0", 8'h00, 32'h7469_6d65);
    api_rd("rd_name1", 8'h01, 32'h7374_6d70);
    api_rd("rd_version", 8'h02, 32'h0002_0000);
    api_rd("rd_channels", 8'h03, 32'd4);
    api_rd("rd_cfg_rst", 8'h10, 32'h1);
    api_wr(8'h11, 32'hdead_beef);
    api_rd("rd_rdly", 8'h11, 32'hdead_beef);
    api_wr(8'h15, 32'h1234_5678);
    api_rd("rd_unmapped", 8'h15, 32'h0);

    rdly = 32'h1007_de1a;
    rdsp = 32'h1007_d155;
    refid = 32'habad_1dea;
    cfg = 32'h0001_0000;
    api_wr(8'h11, rdly);
    api_wr(8'h12, rdsp);
    api_wr(8'h13, refid);
    api_wr(8'h10, cfg);

    cap(4'b0001, t1);
    ntp = t2;
    set_ch(0, 64'hffff_dddd_0000_0005, 3'd4, 8'd6);
    push_hdr(0, t2, 1'b0);
    chk("blk0_model", q[0].d, 64'h2401_0600_1007_de1a);
    pulse_tx(4'b0001);
    chk("busy_ch0", 64'(busy), 64'h1);
    @(negedge clk);
    chk("lat_k1_idle", 64'(bus_if.o_tx_wr_en), 64'd0);
    @(negedge clk);
    chk("lat_k2_blk0", 64'(bus_if.o_tx_wr_en), 64'd1);
    drain("drain_ch0");
    chk("busy_after_ch0", 64'(busy), 64'd0);

    cfg = 32'h0001_0001;
    ofs = 32'h0000_0100;
    api_wr(8'h10, cfg);
    api_wr(8'h14, ofs);
    ntp = t3;
    set_ch(0, 64'h0123_4567_89ab_cdef, 3'd3, 8'hfa);
    push_hdr(0, t3, 1'b0);
    pulse_tx(4'b0001);
    drain("drain_ofs");

    set_ch(1, 64'h1111_2222_3333_4444, 3'd2, 8'd4);
    push_hdr(1, t3, 1'b0);
    pulse_tx(4'b0010);
    drain("drain_ptr");

    cap(4'b1110, t4);
    ntp = t5;
    set_ch(1, 64'haaaa_0001_0000_0001, 3'd1, 8'd1);
    set_ch(2, 64'haaaa_0002_0000_0002, 3'd3, 8'd2);
    set_ch(3, 64'haaaa_0003_0000_0003, 3'd7, 8'd3);
    push_hdr(2, t5, 1'b0);
    push_hdr(3, t5, 1'b1);
    push_hdr(1, t5, 1'b1);
    pulse_tx(4'b1110);
    chk("busy_multi", 64'(busy), 64'hE);
    drain("drain_multi");

    set_ch(1, 64'hbbbb_0001_0000_0001, 3'd4, 8'd9);
    set_ch(2, 64'hbbbb_0002_0000_0002, 3'd4, 8'd10);
    push_hdr(2, t5, 1'b0);
    pulse_tx(4'b0110);
    @(negedge clk);
    clr = 4'b0010;
    txr = 4'b0100;
    @(negedge clk);
    clr = '0;
    txr = '0;
    t_rx[1] = '0;
    chk("busy_after_clear", 64'(busy), 64'h4);
    pulse_tx(4'b0100);
    drain("drain_clear");
    repeat (10) @(negedge clk);
    chk("busy_idle", 64'(busy), 64'd0);

    push_hdr(1, t5, 1'b0);
    pulse_tx(4'b0010);
    drain("drain_rx_cleared");

    set_ch(3, 64'hcccc_0003_0000_0003, 3'd4, 8'd5);
    push_hdr(3, t5, 1'b0);
    pulse_tx(4'b1000);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus_if.o_tx_wr_en === 1'b1 &&
          bus_if.o_tx_ntp_header_block === 3'd3)
        seen = 1'b1;
    end
    chk("blk3_seen", 64'(seen), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_wr_en", 64'(bus_if.o_tx_wr_en), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    q.delete();
    cfg = 32'h1;
    rdly = '0;
    rdsp = '0;
    refid = '0;
    ofs = '0;
    for (int c = 0; c < CH; c++) t_rx[c] = '0;
    repeat (8) @(negedge clk);
    chk("post_rst_quiet", 64'(q.size()), 64'd0);
    api_rd("rd_cfg_midrst", 8'h10, 32'h1);
    api_rd("rd_rdly_midrst", 8'h11, 32'h0);

`ifdef NTS_TIMESTAMP_MC_STATS_EN
    ntp = t4;
    set_ch(0, 64'hdddd_0000_0000_0001, 3'd4, 8'd6);
    for (int k = 0; k < 3; k++) begin
      push_hdr(0, t4, 1'b0);
      pulse_tx(4'b0001);
      drain("drain_stats");
    end
    api_rd("rd_stat0", 8'h20, 32'd3);
    api_rd("rd_stat1", 8'h21, 32'd0);
    api_wr(8'h1f, 32'h0);
    api_rd("rd_stat0_clr", 8'h20, 32'd0);
`else
    ntp = t4;
    set_ch(0, 64'hdddd_0000_0000_0001, 3'd4, 8'd6);
    push_hdr(0, t4, 1'b0);
    pulse_tx(4'b0001);
    drain("drain_nostats");
    api_rd("rd_nostat", 8'h20, 32'd0);
    api_wr(8'h1f, 32'h0);
    api_rd("rd_nostat_1f", 8'h1f, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
